// File: rtl/p2s_shift_out_if.sv
// Parallel-word handshake and serial-chain outputs of the p2s_shift_out reader.
// The master drives start/D; the slave returns status and drives the serial chain.
interface p2s_shift_out_if #(
  parameter int unsigned DATA_W = 32
);
  logic              start;
  logic [DATA_W-1:0] D;
  logic              busy;
  logic              done;
  logic              sclk;
  logic              sdata;
  logic              slatch;

  modport master (
    output start, D,
    input  busy, done, sclk, sdata, slatch
  );

  modport slave (
    input  start, D,
    output busy, done, sclk, sdata, slatch
  );
endinterface

// File: rtl/p2s_shift_out.sv
// Captures a parallel word on start and shifts it out on sdata/sclk.
// After the last bit it strobes slatch so an external SIPO chain presents the word.
module p2s_shift_out #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned CLK_DIV   = 2,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  p2s_shift_out_if.slave  bus
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [DIV_W-1:0] DIV_TC  = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BIT_TOP = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_e;

  state_e            state_q;
  logic [DIV_W-1:0]  div_q;
  logic [CNT_W-1:0]  bit_q;
  logic [DATA_W-1:0] shadow_q;
  logic [DATA_W-1:0] shadow_d;
  logic              busy_q;
  logic              done_q;
  logic              sclk_q;
  logic              sdata_q;
  logic              slatch_q;
  logic              div_tc;
  logic              first_bit;
  logic              next_bit;

  // Shadow register advances so the next bit to send always sits at the output end.
  always_comb begin
    div_tc    = (div_q == DIV_TC);
    shadow_d  = MSB_FIRST ? (shadow_q << 1) : (shadow_q >> 1);
    first_bit = MSB_FIRST ? bus.D[DATA_W-1] : bus.D[0];
    next_bit  = MSB_FIRST ? shadow_d[DATA_W-1] : shadow_d[0];
  end

  // sclk_q doubles as the divider phase: low half then high half per bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      shadow_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sclk_q   <= 1'b0;
      sdata_q  <= 1'b0;
      slatch_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            shadow_q <= bus.D;
            bit_q    <= BIT_TOP;
            div_q    <= '0;
            sclk_q   <= 1'b0;
            sdata_q  <= first_bit;
            busy_q   <= 1'b1;
            state_q  <= SHIFT;
          end
        end
        SHIFT: begin
          if (div_tc) begin
            div_q <= '0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else begin
              sclk_q <= 1'b0;
              if (bit_q != '0) begin
                bit_q    <= bit_q - CNT_W'(1);
                shadow_q <= shadow_d;
                sdata_q  <= next_bit;
              end else begin
                slatch_q <= 1'b1;
                sdata_q  <= 1'b0;
                state_q  <= LATCH;
              end
            end
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        LATCH: begin
          if (div_tc) begin
            div_q    <= '0;
            slatch_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= IDLE;
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.sclk   = sclk_q;
  assign bus.sdata  = sdata_q;
  assign bus.slatch = slatch_q;

endmodule

// File: tb/tb_p2s_shift_out.sv
// Scoreboard bench for p2s_shift_out: a 32-bit/div-2/MSB-first instance and an
// 8-bit/div-1/LSB-first instance, each with its own reference model and monitor.
module tb_p2s_shift_out;

  logic        clk = 1'b0;
  logic        start_s [2];
  logic [31:0] d_s     [2];
  logic        rst_s   [2];
  logic [4:0]  outs    [2];
  int          pend    [2];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gen_cfg
    localparam int unsigned DW  = (g == 0) ? 32 : 8;
    localparam int unsigned CD  = (g == 0) ? 2 : 1;
    localparam bit          MSB = (g == 0);
    localparam int          T   = (2 * DW + 1) * CD;

    p2s_shift_out_if #(.DATA_W(DW)) bus ();

    assign bus.start = start_s[g];
    assign bus.D     = d_s[g][DW-1:0];
    assign outs[g]   = {bus.busy, bus.done, bus.sclk, bus.sdata, bus.slatch};

    p2s_shift_out #(.DATA_W(DW), .CLK_DIV(CD), .MSB_FIRST(MSB)) dut (
      .clk (clk),
      .rst (rst_s[g]),
      .bus (bus)
    );

    // Reference model: a word is accepted when idle and start is high; it then
    // occupies the block for T cycles, after which a new word may be accepted.
    logic [DW-1:0] exp_q[$];
    int busy_left = 0;

    always @(posedge clk) begin
      if (rst_s[g]) begin
        if (busy_left > 0) void'(exp_q.pop_back());
        busy_left = 0;
      end else if (busy_left == 0) begin
        if (start_s[g]) begin
          exp_q.push_back(d_s[g][DW-1:0]);
          busy_left = T;
        end
      end else begin
        busy_left--;
      end
    end

    // Monitor: receiver samples sdata on sclk rise; transfer checked at done.
    logic          p_sclk = 1'b0, p_busy = 1'b0, p_done = 1'b0, p_sdata = 1'b0, act = 1'b0;
    int            rel = 0, rises = 0, bcyc = 0, lcyc = 0, terr = 0, lat_bad = 0, sd_bad = 0;
    logic [DW-1:0] rx = '0;
    logic [DW-1:0] e;

    always @(posedge clk) begin
      #1;
      if (rst_s[g]) begin
        act = 1'b0;
        p_sclk = 1'b0; p_busy = 1'b0; p_done = 1'b0; p_sdata = 1'b0;
      end else begin
        if (bus.busy && !p_busy) begin
          act = 1'b1; rel = 0; rises = 0; bcyc = 0; lcyc = 0;
          terr = 0; lat_bad = 0; sd_bad = 0; rx = '0;
        end else begin
          rel++;
        end
        if (act) begin
          if (bus.busy) bcyc++;
          if (bus.sclk && !p_sclk) begin
            if (rel != (2 * rises + 1) * int'(CD)) terr++;
            rx = MSB ? DW'({rx, bus.sdata}) : (rx | (DW'(bus.sdata) << rises));
            rises++;
          end
          if (!bus.sclk && p_sclk && rel != 2 * rises * int'(CD)) terr++;
          if (bus.sclk && bus.sdata != p_sdata) sd_bad++;
          if (bus.slatch) begin
            if (lcyc == 0 && rel != 2 * int'(DW) * int'(CD)) terr++;
            lcyc++;
            if (bus.sdata) lat_bad++;
          end
        end
        if (bus.done) begin
          chk($sformatf("cfg%0d done_single", g), longint'(p_done), 0);
          if (exp_q.size() == 0) begin
            chk($sformatf("cfg%0d unexpected_done", g), 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("cfg%0d rx_word", g), longint'(rx), longint'(e));
            chk($sformatf("cfg%0d sclk_rises", g), rises, DW);
            chk($sformatf("cfg%0d busy_cycles", g), bcyc, T);
            chk($sformatf("cfg%0d slatch_cycles", g), lcyc, CD);
            chk($sformatf("cfg%0d edge_timing_errs", g), terr, 0);
            chk($sformatf("cfg%0d done_edge", g), rel, T);
            chk($sformatf("cfg%0d sdata_glitches", g), lat_bad + sd_bad, 0);
          end
          act = 1'b0;
        end
        p_sclk = bus.sclk; p_busy = bus.busy; p_done = bus.done; p_sdata = bus.sdata;
      end
      pend[g] = exp_q.size();
    end
  end

  task automatic drv(input int g, input logic st, input logic [31:0] d, input logic r,
                     input int n);
    repeat (n) begin
      @(negedge clk);
      start_s[g] = st;
      d_s[g]     = d;
      rst_s[g]   = r;
    end
  endtask

  task automatic seq_cfg0();
    int bad;
    bit found;
    drv(0, 1'b0, 32'h0, 1'b1, 3);
    drv(0, 1'b0, 32'h0, 1'b0, 1);
    @(posedge clk); #1;
    chk("cfg0 reset_outputs", longint'(outs[0]), 0);
    // Idle: nothing moves without start.
    bad = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (outs[0] != 5'd0) bad++;
    end
    chk("cfg0 idle_quiet_cycles", bad, 0);
    drv(0, 1'b1, 32'hA5A5_0F0F, 1'b0, 1);
    drv(0, 1'b0, 32'h0, 1'b0, 140);
    // start held; D changes during busy; second word must follow with no gap.
    drv(0, 1'b1, 32'h1234_5678, 1'b0, 1);
    drv(0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1);
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(posedge clk); #1;
      if (outs[0][3]) begin
        found = 1'b1;
        @(posedge clk); #1;
        chk("cfg0 no_gap_busy", longint'(outs[0][4]), 1);
      end
    end
    chk("cfg0 done_seen_b2b", longint'(found), 1);
    drv(0, 1'b0, 32'h0, 1'b0, 140);
    drv(0, 1'b1, 32'h0000_0000, 1'b0, 1);
    drv(0, 1'b0, 32'hFFFF_FFFF, 1'b0, 140);
    drv(0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1);
    drv(0, 1'b0, 32'h0, 1'b0, 140);
    // Abort mid-transfer.
    drv(0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1);
    drv(0, 1'b0, 32'h0, 1'b0, 40);
    drv(0, 1'b0, 32'h0, 1'b1, 1);
    @(posedge clk); #1;
    chk("cfg0 abort_outputs", longint'(outs[0]), 0);
    drv(0, 1'b0, 32'h0, 1'b0, 150);
    drv(0, 1'b1, 32'h0BAD_CAFE, 1'b0, 1);
    drv(0, 1'b0, 32'h0, 1'b0, 140);
    for (int i = 0; i < 1500; i++)
      drv(0, ($urandom % 6) == 0, $urandom, ($urandom % 400) == 0, 1);
    drv(0, 1'b0, 32'h0, 1'b0, 150);
  endtask

  task automatic seq_cfg1();
    drv(1, 1'b0, 32'h0, 1'b1, 2);
    drv(1, 1'b0, 32'h0, 1'b0, 2);
    drv(1, 1'b1, 32'h0000_0081, 1'b0, 1);
    drv(1, 1'b0, 32'h0, 1'b0, 25);
    for (int i = 0; i < 400; i++)
      drv(1, ($urandom % 3) == 0, $urandom, ($urandom % 150) == 0, 1);
    drv(1, 1'b0, 32'h0, 1'b0, 30);
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      start_s[g] = 1'b0;
      d_s[g]     = 32'h0;
      rst_s[g]   = 1'b1;
      pend[g]    = 0;
    end
    fork
      seq_cfg0();
      seq_cfg1();
    join
    @(posedge clk); #2;
    chk("cfg0 pending_at_end", pend[0], 0);
    chk("cfg1 pending_at_end", pend[1], 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
